// File: rtl/exe_if.sv
// ID/EX inputs, EX/MEM outputs and the stall/flush handshake of the execute stage.
interface exe_if;
  logic        flush;
  logic        valid_in;
  logic [31:0] pc_in;
  logic        wb_en_in;
  logic        mem_r_en_in;
  logic        mem_w_en_in;
  logic [3:0]  ex_cmd;
  logic [31:0] val1;
  logic [31:0] val2;
  logic [31:0] reg2;
  logic [4:0]  dst_in;

  logic        stall;
  logic        valid_out;
  logic        wb_en_out;
  logic        mem_r_en_out;
  logic        mem_w_en_out;
  logic [31:0] alu_res;
  logic [31:0] st_val;
  logic [31:0] pc_out;
  logic [4:0]  dst_out;

  modport master (
    output flush, valid_in, pc_in, wb_en_in, mem_r_en_in, mem_w_en_in, ex_cmd, val1, val2,
           reg2, dst_in,
    input  stall, valid_out, wb_en_out, mem_r_en_out, mem_w_en_out, alu_res, st_val, pc_out,
           dst_out
  );

  modport slave (
    input  flush, valid_in, pc_in, wb_en_in, mem_r_en_in, mem_w_en_in, ex_cmd, val1, val2,
           reg2, dst_in,
    output stall, valid_out, wb_en_out, mem_r_en_out, mem_w_en_out, alu_res, st_val, pc_out,
           dst_out
  );
endinterface

// File: rtl/exe_stage.sv
// Execute stage: single-cycle ALU plus a 32-step shift-add multiplier that stalls upstream,
// feeding the EX/MEM pipeline register.
module exe_stage (
  input  logic clk,
  input  logic rst,
  exe_if.slave bus
);
  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  localparam logic [3:0] CmdMov = 4'b0000;
  localparam logic [3:0] CmdAdd = 4'b0001;
  localparam logic [3:0] CmdSub = 4'b0010;
  localparam logic [3:0] CmdAnd = 4'b0011;
  localparam logic [3:0] CmdOr  = 4'b0100;
  localparam logic [3:0] CmdXor = 4'b0101;
  localparam logic [3:0] CmdSlt = 4'b0110;
  localparam logic [3:0] CmdSll = 4'b0111;
  localparam logic [3:0] CmdSrl = 4'b1000;
  localparam logic [3:0] CmdSra = 4'b1001;
  localparam logic [3:0] CmdMul = 4'b1010;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;
  logic [31:0] prod_q, prod_d;

  logic        valid_q, valid_d;
  logic        wb_en_q, wb_en_d;
  logic        mem_r_en_q, mem_r_en_d;
  logic        mem_w_en_q, mem_w_en_d;
  logic [31:0] alu_res_q, alu_res_d;
  logic [31:0] st_val_q, st_val_d;
  logic [31:0] pc_q, pc_d;
  logic [4:0]  dst_q, dst_d;

  logic        mul_start;
  logic        stall;
  logic        capture;
  logic [31:0] alu_out;

  assign mul_start = (state_q == StIdle) && bus.valid_in && (bus.ex_cmd == CmdMul) && !bus.flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    if (bus.flush) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (mul_start) begin
            state_d  = StBusy;
            cnt_d    = '0;
            mcand_d  = bus.val1;
            mplier_d = bus.val2;
            prod_d   = '0;
          end
        end
        StBusy: begin
          // Shift-add: the low multiplier bit selects the current shifted multiplicand.
          if (mplier_q[0]) prod_d = prod_q + mcand_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_d = StDone;
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    stall   = 1'b0;
    capture = 1'b0;
    if (!bus.flush) begin
      unique case (state_q)
        StIdle: begin
          stall   = mul_start;
          capture = bus.valid_in && !mul_start;
        end
        StBusy:  stall = 1'b1;
        StDone:  capture = 1'b1;
        default: ;
      endcase
    end
  end

  // In StDone the held opcode is still MUL, so the MUL slot reads the finished product.
  always_comb begin
    alu_out = '0;
    unique case (bus.ex_cmd)
      CmdMov:  alu_out = bus.val2;
      CmdAdd:  alu_out = bus.val1 + bus.val2;
      CmdSub:  alu_out = bus.val1 - bus.val2;
      CmdAnd:  alu_out = bus.val1 & bus.val2;
      CmdOr:   alu_out = bus.val1 | bus.val2;
      CmdXor:  alu_out = bus.val1 ^ bus.val2;
      CmdSlt:  alu_out = {31'd0, $signed(bus.val1) < $signed(bus.val2)};
      CmdSll:  alu_out = bus.val1 << bus.val2[4:0];
      CmdSrl:  alu_out = bus.val1 >> bus.val2[4:0];
      CmdSra:  alu_out = $unsigned($signed(bus.val1) >>> bus.val2[4:0]);
      CmdMul:  alu_out = prod_q;
      default: alu_out = '0;
    endcase
  end

  // Bubbles clear the control bits and leave the data fields holding their last value.
  always_comb begin
    valid_d    = 1'b0;
    wb_en_d    = 1'b0;
    mem_r_en_d = 1'b0;
    mem_w_en_d = 1'b0;
    alu_res_d  = alu_res_q;
    st_val_d   = st_val_q;
    pc_d       = pc_q;
    dst_d      = dst_q;
    if (capture) begin
      valid_d    = 1'b1;
      wb_en_d    = bus.wb_en_in;
      mem_r_en_d = bus.mem_r_en_in;
      mem_w_en_d = bus.mem_w_en_in;
      alu_res_d  = alu_out;
      st_val_d   = bus.reg2;
      pc_d       = bus.pc_in;
      dst_d      = bus.dst_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= 1'b0;
      wb_en_q    <= 1'b0;
      mem_r_en_q <= 1'b0;
      mem_w_en_q <= 1'b0;
      alu_res_q  <= '0;
      st_val_q   <= '0;
      pc_q       <= '0;
      dst_q      <= '0;
    end else begin
      valid_q    <= valid_d;
      wb_en_q    <= wb_en_d;
      mem_r_en_q <= mem_r_en_d;
      mem_w_en_q <= mem_w_en_d;
      alu_res_q  <= alu_res_d;
      st_val_q   <= st_val_d;
      pc_q       <= pc_d;
      dst_q      <= dst_d;
    end
  end

  assign bus.stall        = stall;
  assign bus.valid_out    = valid_q;
  assign bus.wb_en_out    = wb_en_q;
  assign bus.mem_r_en_out = mem_r_en_q;
  assign bus.mem_w_en_out = mem_w_en_q;
  assign bus.alu_res      = alu_res_q;
  assign bus.st_val       = st_val_q;
  assign bus.pc_out       = pc_q;
  assign bus.dst_out      = dst_q;
endmodule

// File: tb/tb_exe_stage.sv
// Bench for exe_stage: vector table of ALU ops, then multiply, flush and reset sequences,
// with expected EX/MEM contents queued before each edge and checked after it.
module tb_exe_stage;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  exe_if bus ();

  exe_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic        valid;
    logic        wb;
    logic        mr;
    logic        mw;
    logic [31:0] res;
    logic [31:0] st;
    logic [31:0] pc;
    logic [4:0]  dst;
  } out_t;

  typedef struct {
    logic        valid;
    logic [3:0]  cmd;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  dst;
    logic        wb;
    logic        mr;
    logic        mw;
    logic [31:0] res;
  } vec_t;

  int   total = 0;
  int   bad = 0;
  out_t exp_q[$];
  out_t bubble = '0;

  function automatic logic [31:0] model(input logic [3:0] c, input logic [31:0] a, b);
    case (c)
      4'd0:    return b;
      4'd1:    return a + b;
      4'd2:    return a - b;
      4'd3:    return a & b;
      4'd4:    return a | b;
      4'd5:    return a ^ b;
      4'd6:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd7:    return a << b[4:0];
      4'd8:    return a >> b[4:0];
      4'd9:    return $unsigned($signed(a) >>> b[4:0]);
      4'd10:   return a * b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic out_t sample();
    out_t o;
    o.valid = bus.valid_out;
    o.wb    = bus.wb_en_out;
    o.mr    = bus.mem_r_en_out;
    o.mw    = bus.mem_w_en_out;
    o.res   = bus.alu_res;
    o.st    = bus.st_val;
    o.pc    = bus.pc_out;
    o.dst   = bus.dst_out;
    return o;
  endfunction

  function automatic out_t mk(input logic wb, mr, mw, input logic [31:0] res, st, pc,
                              input logic [4:0] dst);
    out_t o;
    o.valid = 1'b1;
    o.wb    = wb;
    o.mr    = mr;
    o.mw    = mw;
    o.res   = res;
    o.st    = st;
    o.pc    = pc;
    o.dst   = dst;
    return o;
  endfunction

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] cmd, input logic [31:0] a, b,
                       input logic [4:0] dst, input logic [31:0] pc, st,
                       input logic wb, mr, mw, fl);
    bus.valid_in    = v;
    bus.ex_cmd      = cmd;
    bus.val1        = a;
    bus.val2        = b;
    bus.dst_in      = dst;
    bus.pc_in       = pc;
    bus.reg2        = st;
    bus.wb_en_in    = wb;
    bus.mem_r_en_in = mr;
    bus.mem_w_en_in = mw;
    bus.flush       = fl;
  endtask

  // Inputs are already driven; checks stall mid-cycle, then the EX/MEM register after the edge.
  task automatic step(input string name, input logic exp_stall, input out_t exp);
    out_t got;
    out_t e;
    @(negedge clk);
    chk({name, "_stall"}, {127'd0, bus.stall}, {127'd0, exp_stall});
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    got = sample();
    e = exp_q.pop_front();
    if (e.valid) chk(name, {23'd0, got}, {23'd0, e});
    else chk(name, {124'd0, got.valid, got.wb, got.mr, got.mw},
             {124'd0, e.valid, e.wb, e.mr, e.mw});
  endtask

  vec_t vecs[$];

  initial begin
    vecs.push_back('{1'b1, 4'd1,  32'hFFFFFFFF, 32'h1,        5'd5,  1'b1, 1'b0, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 4'd6,  32'h80000000, 32'h1,        5'd6,  1'b1, 1'b0, 1'b0, 32'h1});
    vecs.push_back('{1'b1, 4'd9,  32'h80000000, 32'h4,        5'd7,  1'b1, 1'b0, 1'b0,
                     32'hF8000000});
    vecs.push_back('{1'b1, 4'd0,  32'hDEADBEEF, 32'h1234,     5'd8,  1'b1, 1'b0, 1'b0,
                     32'h1234});
    vecs.push_back('{1'b1, 4'd2,  32'h5,        32'h7,        5'd9,  1'b0, 1'b1, 1'b0,
                     32'hFFFFFFFE});
    vecs.push_back('{1'b1, 4'd3,  32'hF0F0F0F0, 32'hFF00FF00, 5'd10, 1'b0, 1'b0, 1'b1,
                     32'hF000F000});
    vecs.push_back('{1'b1, 4'd4,  32'hF0F0F0F0, 32'h0F0F0F0F, 5'd11, 1'b1, 1'b0, 1'b0,
                     32'hFFFFFFFF});
    vecs.push_back('{1'b1, 4'd5,  32'hAAAA5555, 32'hFFFF0000, 5'd12, 1'b1, 1'b0, 1'b0,
                     32'h55555555});
    vecs.push_back('{1'b1, 4'd6,  32'h1,        32'h80000000, 5'd13, 1'b1, 1'b0, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 4'd7,  32'h1,        32'd31,       5'd14, 1'b1, 1'b0, 1'b0,
                     32'h80000000});
    vecs.push_back('{1'b1, 4'd7,  32'h1,        32'd33,       5'd15, 1'b1, 1'b0, 1'b0, 32'h2});
    vecs.push_back('{1'b1, 4'd8,  32'h80000000, 32'h4,        5'd16, 1'b1, 1'b0, 1'b0,
                     32'h08000000});
    vecs.push_back('{1'b1, 4'd11, 32'h12345678, 32'h1,        5'd17, 1'b1, 1'b0, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 4'd15, 32'h12345678, 32'h1,        5'd18, 1'b1, 1'b0, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 4'd1,  32'h1,        32'h1,        5'd19, 1'b1, 1'b1, 1'b1, 32'h2});

    rst = 1'b1;
    drive(1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #12;
    chk("reset_outputs", {23'd0, sample()}, 128'd0);
    chk("reset_stall", {127'd0, bus.stall}, 128'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      logic [31:0] pc;
      logic [31:0] st;
      pc = 32'h1000 + 32'(i * 4);
      st = ~vecs[i].a;
      drive(vecs[i].valid, vecs[i].cmd, vecs[i].a, vecs[i].b, vecs[i].dst, pc, st,
            vecs[i].wb, vecs[i].mr, vecs[i].mw, 1'b0);
      step($sformatf("vec%0d", i), 1'b0, vecs[i].valid ?
           mk(vecs[i].wb, vecs[i].mr, vecs[i].mw, vecs[i].res, st, pc, vecs[i].dst) : bubble);
    end

    // Multiply: 33 stalled bubbles, the product, then a held ADD with no gap.
    drive(1'b1, 4'd10, 32'h00010003, 32'h00020005, 5'd9, 32'h2000, 32'hCAFE,
          1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 33; i++) step($sformatf("mul_stall%0d", i), 1'b1, bubble);
    step("mul_done", 1'b0, mk(1'b1, 1'b0, 1'b0, 32'h000B000F, 32'hCAFE, 32'h2000, 5'd9));
    drive(1'b1, 4'd1, 32'd2, 32'd3, 5'd3, 32'h2004, 32'hBEEF, 1'b1, 1'b0, 1'b0, 1'b0);
    step("add_after_mul", 1'b0, mk(1'b1, 1'b0, 1'b0, 32'd5, 32'hBEEF, 32'h2004, 5'd3));

    // Flush at BUSY cnt=10 discards the multiply.
    drive(1'b1, 4'd10, 32'd7, 32'd9, 5'd4, 32'h3000, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("fl_accept", 1'b1, bubble);
    for (int i = 0; i < 10; i++) step($sformatf("fl_busy%0d", i), 1'b1, bubble);
    bus.flush = 1'b1;
    step("fl_flush", 1'b0, bubble);
    drive(1'b0, 4'd10, 32'd7, 32'd9, 5'd4, 32'h3000, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      step($sformatf("fl_after%0d", i), 1'b0, bubble);
      total++;
      if (bus.alu_res == 32'd63) begin
        bad++;
        $display("FAIL fl_noprod%0d: alu_res=%0h must not be 3f", i, bus.alu_res);
      end
    end

    // MUL with flush in the same cycle, and MUL with valid_in=0, must not start.
    drive(1'b1, 4'd10, 32'd3, 32'd3, 5'd1, 32'h4000, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    step("mulfl_same", 1'b0, bubble);
    drive(1'b0, 4'd10, 32'd3, 32'd3, 5'd1, 32'h4000, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("mulfl_next", 1'b0, bubble);
    step("mulinv_next", 1'b0, bubble);

    // Asynchronous reset mid-BUSY.
    drive(1'b1, 4'd10, 32'd5, 32'd6, 5'd2, 32'h5000, 32'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    step("rst_accept", 1'b1, bubble);
    for (int i = 0; i < 5; i++) step($sformatf("rst_busy%0d", i), 1'b1, bubble);
    #2;
    rst = 1'b1;
    bus.valid_in = 1'b0;
    #1;
    chk("rst_mid_outputs", {23'd0, sample()}, 128'd0);
    chk("rst_mid_stall", {127'd0, bus.stall}, 128'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    drive(1'b1, 4'd1, 32'd10, 32'd20, 5'd7, 32'h6000, 32'h77, 1'b1, 1'b0, 1'b1, 1'b0);
    step("rst_then_add", 1'b0, mk(1'b1, 1'b0, 1'b1, 32'd30, 32'h77, 32'h6000, 5'd7));

    // Random single-cycle ops against the reference model.
    for (int i = 0; i < 20; i++) begin
      logic [3:0]  c;
      logic [31:0] a;
      logic [31:0] b;
      c = 4'($urandom_range(0, 15));
      if (c == 4'd10) c = 4'd1;
      a = $urandom;
      b = $urandom;
      drive(1'b1, c, a, b, 5'(i), 32'h7000 + 32'(i), ~b, 1'b1, 1'b0, 1'b0, 1'b0);
      step($sformatf("rand%0d", i), 1'b0,
           mk(1'b1, 1'b0, 1'b0, model(c, a, b), ~b, 32'h7000 + 32'(i), 5'(i)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/exe_stage.md
EXE_STAGE -- requirements
Module: exe_stage

Interface
REQ-001 clk  input  1  pipeline clock; all state updates on rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 flush  input  1  synchronous squash of in-flight work (branch redirect).
REQ-004 valid_in  input  1  ID/EX register holds a real instruction.
REQ-005 pc_in  input  32  PC of the instruction, passed through.
REQ-006 wb_en_in, mem_r_en_in, mem_w_en_in  input  1 each  control bits from ID/EX.
REQ-007 ex_cmd  input  4  operation select.
REQ-008 val1, val2  input  32 each  ALU operands.
REQ-009 reg2  input  32  store data.
REQ-010 dst_in  input  5  destination register.
REQ-011 stall  output  1  combinational; when 1, upstream holds the ID/EX register and the PC.
REQ-012 valid_out, wb_en_out, mem_r_en_out, mem_w_en_out  output  1 each  registered EX/MEM control.
REQ-013 alu_res, st_val, pc_out  output  32 each  registered result, store data, PC.
REQ-014 dst_out  output  5  registered destination.

Function
REQ-015 ex_cmd encoding: 0000 MOV=val2; 0001 ADD; 0010 SUB=val1-val2; 0011 AND; 0100 OR; 0101 XOR; 0110 SLT signed (result 1/0); 0111 SLL val1<<val2[4:0]; 1000 SRL; 1001 SRA; 1010 MUL; 1011-1111 result 0.
REQ-016 ADD/SUB/MUL wrap modulo 2^32; MUL result is the low 32 bits of the unsigned product (identical to signed for the low half).
REQ-017 Single-cycle ops: stall=0; the EX/MEM register captures the result and all pass-through fields on the next edge.
REQ-018 MUL FSM states IDLE, BUSY, DONE; reset state IDLE.
REQ-019 IDLE with valid_in=1, ex_cmd=MUL: stall=1, latch operands, cnt<=0, go BUSY.
REQ-020 BUSY: stall=1; one shift-add step per cycle; cnt increments; at cnt=31 go DONE (BUSY lasts exactly 32 cycles).
REQ-021 DONE: stall=0; the EX/MEM register captures the product plus the held ID/EX fields; go IDLE.
REQ-022 MUL latency: accept cycle + 32 BUSY cycles + DONE cycle; stall high exactly 33 consecutive cycles.
REQ-023 While stall=1, the EX/MEM register loads a bubble: valid_out, wb_en_out, mem_r_en_out and mem_w_en_out =0; data fields don't-care.
REQ-024 valid_in=0: the EX/MEM register loads a bubble; a MUL opcode with valid_in=0 does not start the FSM.
REQ-025 flush=1: the EX/MEM register loads a bubble, FSM goes to IDLE, cnt cleared, stall=0 that cycle; flush has priority over all other events.
REQ-026 MUL in IDLE with flush=1 the same cycle: not accepted.
REQ-027 Back-to-back MUL: the second MUL is accepted in the cycle after DONE, when IDLE sees it.
REQ-028 Upstream inputs are stable while stall=1; the block does not re-check ex_cmd in BUSY or DONE.

Reset
REQ-029 rst=1 asynchronously forces all EX/MEM outputs to 0, FSM to IDLE, cnt and operand latches to 0.
REQ-030 After reset stall=0, and stays 0 until a valid MUL is presented.
REQ-031 rst asserted mid-MUL aborts the multiply; no partial result reaches alu_res.

Verification
REQ-032 ADD, val1=0xFFFFFFFF, val2=1, dst_in=5, wb_en_in=1 -> next edge alu_res=0, dst_out=5, wb_en_out=1, valid_out=1, stall=0.
REQ-033 SLT, val1=0x80000000, val2=1 -> alu_res=1; SRA, val1=0x80000000, val2=4 -> alu_res=0xF8000000.
REQ-034 MUL, val1=0x00010003, val2=0x00020005 -> stall=1 for 33 cycles with valid_out=0 throughout, then alu_res=0x000B000F with valid_out=1 for one cycle.
REQ-035 flush at BUSY cnt=10 -> next cycle stall=0, state IDLE, valid_out=0; no product is ever written.
REQ-036 rst pulsed mid-BUSY -> all outputs 0 immediately; the next ADD completes in 1 cycle.
REQ-037 MUL then ADD (ADD held upstream) -> the product appears, then the ADD result on the following edge, with no bubble between them.
